// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command decoder with response FIFO and transmit sequencer.
// Optional echo of every received byte is enabled with `define UART_CMD_ECHO_EN.
module uart_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       run_pulse,
    output logic       stop_pulse,
    output logic       clear_pulse,
    output logic       mode_pulse,
    output logic       cmd_err,
    output logic       fifo_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    tx_state_t         state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              run_q, run_d;
    logic              stop_q, stop_d;
    logic              clear_q, clear_d;
    logic              mode_q, mode_d;
    logic              err_q, err_d;
    logic [7:0]        resp_q, resp_d;
    logic              resp_pend_q, resp_pend_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              dec_run, dec_stop, dec_clear, dec_mode, dec_ign, dec_err;
    logic              busy_rx, accept;
    logic              push_req, do_push, do_pop, full;
    logic [7:0]        push_data;

`ifdef UART_CMD_ECHO_EN
    logic [7:0]        echo_q, echo_d;
    logic              echo_pend_q, echo_pend_d;
    logic              resp_ok_q, resp_ok_d;
`endif

    always_comb begin
        dec_run   = (rx_data == 8'h72) || (rx_data == 8'h52);
        dec_stop  = (rx_data == 8'h73) || (rx_data == 8'h53);
        dec_clear = (rx_data == 8'h63) || (rx_data == 8'h43);
        dec_mode  = (rx_data == 8'h6D) || (rx_data == 8'h4D);
        dec_ign   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        dec_err   = !(dec_run || dec_stop || dec_clear || dec_mode || dec_ign);
    end

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign do_pop = (state_q == IDLE) && (count_q != '0) && !tx_busy;

    // A byte still waiting to reach the FIFO blocks new captures entirely.
    always_comb begin
        run_d     = 1'b0;
        stop_d    = 1'b0;
        clear_d   = 1'b0;
        mode_d    = 1'b0;
        err_d     = 1'b0;
        resp_d    = resp_q;
`ifdef UART_CMD_ECHO_EN
        busy_rx     = echo_pend_q || resp_pend_q;
        accept      = rx_done && !busy_rx;
        echo_d      = accept ? rx_data : echo_q;
        echo_pend_d = accept;
        resp_ok_d   = accept ? !dec_ign : resp_ok_q;
        resp_pend_d = echo_pend_q && resp_ok_q;
        push_req    = echo_pend_q || resp_pend_q;
        push_data   = echo_pend_q ? echo_q : resp_q;
`else
        busy_rx     = resp_pend_q;
        accept      = rx_done && !busy_rx;
        resp_pend_d = accept && !dec_ign;
        push_req    = resp_pend_q;
        push_data   = resp_q;
`endif
        if (accept) begin
            run_d   = dec_run;
            stop_d  = dec_stop;
            clear_d = dec_clear;
            mode_d  = dec_mode;
            err_d   = dec_err;
            if (dec_run)        resp_d = 8'h52;
            else if (dec_stop)  resp_d = 8'h53;
            else if (dec_clear) resp_d = 8'h43;
            else if (dec_mode)  resp_d = 8'h4D;
            else                resp_d = 8'h3F;
        end
    end

    // Push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_push  = push_req && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (do_pop) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            run_q       <= 1'b0;
            stop_q      <= 1'b0;
            clear_q     <= 1'b0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            resp_q      <= 8'h00;
            resp_pend_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef UART_CMD_ECHO_EN
            echo_q      <= 8'h00;
            echo_pend_q <= 1'b0;
            resp_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            run_q       <= run_d;
            stop_q      <= stop_d;
            clear_q     <= clear_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            resp_q      <= resp_d;
            resp_pend_q <= resp_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef UART_CMD_ECHO_EN
            echo_q      <= echo_d;
            echo_pend_q <= echo_pend_d;
            resp_ok_q   <= resp_ok_d;
`endif
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign run_pulse   = run_q;
    assign stop_pulse  = stop_q;
    assign clear_pulse = clear_q;
    assign mode_pulse  = mode_q;
    assign cmd_err     = err_q;
    assign fifo_full   = full;

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response FIFO depth in bytes (power of two, 2..16).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_data  input  8  received byte from UART receiver, valid when rx_done=1.
REQ-005 rx_done  input  1  one-cycle strobe, new byte on rx_data.
REQ-006 tx_busy  input  1  UART transmitter busy level.
REQ-007 tx_start  output  1  one-cycle strobe to UART transmitter.
REQ-008 tx_data  output  8  byte to transmit, registered, valid with tx_start and held until next tx_start.
REQ-009 run_pulse, stop_pulse, clear_pulse, mode_pulse  output  1 each  one-cycle counter control strobes.
REQ-010 cmd_err  output  1  one-cycle strobe, unrecognised command byte.
REQ-011 fifo_full  output  1  level, response FIFO full.

Function
REQ-012 Command decode on rx_done: 'r'/'R' -> run_pulse; 's'/'S' -> stop_pulse; 'c'/'C' -> clear_pulse; 'm'/'M' -> mode_pulse; 0x0D and 0x0A -> ignored, no pulse, no response; any other byte -> cmd_err.
REQ-013 rx_data is captured on the rising edge where rx_done=1 (cycle t); the decoded strobe is high during cycle t+1 only.
REQ-014 Response byte: uppercase of the command letter for valid commands ('R','S','C','M'); '?' (0x3F) for errors.
REQ-015 Response push into FIFO occurs at edge ending cycle t+1 (macro off) or t+2 (macro on, see REQ-030).
REQ-016 rx_done asserted while a previous byte is still pending push is ignored entirely (no strobe, no push).
REQ-017 FIFO push when full and no pop in the same cycle: byte dropped, FIFO unchanged, no other side effect.
REQ-018 FIFO push and pop in the same cycle: both performed, including when full; occupancy unchanged.
REQ-019 FIFO pop on empty never occurs; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-020 fifo_full = (occupancy == FIFO_DEPTH), registered-state-derived, no combinational path from inputs.
REQ-021 Transmit FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE: if FIFO non-empty and tx_busy=0 -> tx_start=1 for one cycle, tx_data=FIFO head, pop head, go WAIT_BUSY; else stay.
REQ-023 WAIT_BUSY: stay until tx_busy=1, then go WAIT_DONE.
REQ-024 WAIT_DONE: stay until tx_busy=0, then go IDLE.
REQ-025 Minimum spacing between tx_start strobes: tx_start, tx_busy rise, tx_busy fall, then IDLE check; no tx_start while tx_busy=1.
REQ-026 Bytes leave FIFO strictly in push order.

Reset
REQ-027 On rst=1 (asynchronous): all strobes 0, tx_data=0x00, fifo_full=0, FIFO empty, pointers 0, pending-push flag cleared, FSM=IDLE.
REQ-028 Reset mid-transmission: FSM returns to IDLE immediately; queued bytes discarded; after release the block waits for tx_busy=0 before any tx_start.
REQ-029 First rx_done honoured on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro UART_CMD_ECHO_EN defined: every received byte, including CR/LF and errors, is pushed as an echo at the edge ending cycle t+1, the response (if any) at the edge ending t+2; each push independently subject to REQ-017.
REQ-031 Macro UART_CMD_ECHO_EN undefined: no echo logic; only responses per REQ-014/015.

Verification
REQ-032 rx_data=0x72 'r' with rx_done, tx_busy=0 -> run_pulse high exactly cycle t+1; tx_start one cycle with tx_data=0x52 (macro off).
REQ-033 Macro on, rx_data=0x63 'c' -> clear_pulse at t+1; tx sequence 0x63 then 0x43, second tx_start only after tx_busy fall.
REQ-034 rx_data=0x7A 'z' -> cmd_err at t+1, tx_data=0x3F; rx_data=0x0D -> no strobe, no tx_start.
REQ-035 Hold tx_busy=1, send 6 valid commands 's' -> fifo_full=1 after 4th, bytes 5-6 dropped; release tx_busy -> exactly four 0x53 transmitted.
REQ-036 Assert rst during WAIT_DONE with 3 bytes queued -> all outputs 0, FIFO empty; after release no tx_start occurs.
